// File: rtl/quad_step_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : quad_step_decoder_if
// Brief    : Encoder-side inputs and step/direction/error outputs of the
//            quadrature decoder. QUAD_ERR_CNT_EN adds the err_count field.
// Revision : 1.0 - initial release
// ============================================================================
interface quad_step_decoder_if;
    logic       phase_a;
    logic       phase_b;
    logic       enable;
    logic       err_clr;
    logic       step;
    logic       ud;
    logic       err;
    logic       err_sticky;
`ifdef QUAD_ERR_CNT_EN
    logic [7:0] err_count;

    modport master (
        output phase_a, phase_b, enable, err_clr,
        input  step, ud, err, err_sticky, err_count
    );
    modport slave (
        input  phase_a, phase_b, enable, err_clr,
        output step, ud, err, err_sticky, err_count
    );
`else
    modport master (
        output phase_a, phase_b, enable, err_clr,
        input  step, ud, err, err_sticky
    );
    modport slave (
        input  phase_a, phase_b, enable, err_clr,
        output step, ud, err, err_sticky
    );
`endif
endinterface
`default_nettype wire

// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_step_decoder
// Brief    : Synchronises, glitch-filters and decodes quadrature phases into
//            step/ud strobes; flags double-bit jumps. Optional QUAD_ERR_CNT_EN
//            adds a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module quad_step_decoder #(
    parameter int FILTER_LEN      = 2,
    parameter int STEPS_PER_PULSE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    quad_step_decoder_if.slave    bus
);
    localparam int c_cnt_w = $clog2(FILTER_LEN + 1);
    localparam int c_acc_w = $clog2(STEPS_PER_PULSE) + 2;
    localparam logic [c_cnt_w-1:0]        c_filter_len  = c_cnt_w'(FILTER_LEN);
    localparam logic [c_cnt_w-1:0]        c_cnt_one     = c_cnt_w'(1);
    localparam logic signed [c_acc_w-1:0] c_acc_one     = c_acc_w'(1);
    localparam logic signed [c_acc_w-1:0] c_acc_max     = c_acc_w'(STEPS_PER_PULSE);
    localparam logic signed [c_acc_w-1:0] c_acc_min     = -c_acc_max;
    localparam logic [1:0]                c_settle_last = 2'd2;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        TRACK  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                settle_cnt_q, settle_cnt_d;
    logic [1:0]                prev_q, prev_d;
    logic signed [c_acc_w-1:0] acc_q, acc_d, acc_next;
    logic                      step_q, step_d;
    logic                      ud_q, ud_d;
    logic                      err_q, err_d;
    logic                      err_sticky_q, err_sticky_d;
    logic                      fwd, rev;

    logic [1:0] phase_raw;
    logic [1:0] s2_w;
    logic [1:0] filt_w;

    assign phase_raw = {bus.phase_b, bus.phase_a};

    // Index 0 is phase A, index 1 is phase B.
    generate
        for (genvar i = 0; i < 2; i++) begin : g_phase
            logic               s1_q, s2_q;
            logic               filt_q, filt_d;
            logic [c_cnt_w-1:0] cnt_q, cnt_d;

            always_comb begin
                filt_d = filt_q;
                cnt_d  = '0;
                if (state_q == SETTLE) begin
                    filt_d = s2_q;
                end else if (s2_q != filt_q) begin
                    if (cnt_q + c_cnt_one == c_filter_len) begin
                        filt_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    filt_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    s1_q   <= phase_raw[i];
                    s2_q   <= s1_q;
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign s2_w[i]   = s2_q;
            assign filt_w[i] = filt_q;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        prev_d       = prev_q;
        acc_d        = acc_q;
        acc_next     = acc_q;
        step_d       = 1'b0;
        ud_d         = ud_q;
        err_d        = 1'b0;
        fwd          = 1'b0;
        rev          = 1'b0;
        case (state_q)
            SETTLE: begin
                settle_cnt_d = settle_cnt_q + 2'd1;
                if (settle_cnt_q == c_settle_last) begin
                    state_d      = TRACK;
                    settle_cnt_d = '0;
                    // Same value the filters load this cycle, so no false edge on entry.
                    prev_d       = s2_w;
                end
            end
            TRACK: begin
                prev_d = filt_w;
                case ({prev_q, filt_w})
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
                    4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rev = 1'b1;
                    default: ;
                endcase
                err_d = ((prev_q ^ filt_w) == 2'b11);
                if (bus.enable && (fwd || rev)) begin
                    acc_next = fwd ? acc_q + c_acc_one : acc_q - c_acc_one;
                    if (acc_next == c_acc_max) begin
                        step_d = 1'b1;
                        ud_d   = 1'b0;
                        acc_d  = '0;
                    end else if (acc_next == c_acc_min) begin
                        step_d = 1'b1;
                        ud_d   = 1'b1;
                        acc_d  = '0;
                    end else begin
                        acc_d  = acc_next;
                    end
                end
            end
            default: state_d = SETTLE;
        endcase
        err_sticky_d = err_d | (err_sticky_q & ~bus.err_clr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= SETTLE;
            settle_cnt_q <= '0;
            prev_q       <= '0;
            acc_q        <= '0;
            step_q       <= 1'b0;
            ud_q         <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            prev_q       <= prev_d;
            acc_q        <= acc_d;
            step_q       <= step_d;
            ud_q         <= ud_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.step       = step_q;
    assign bus.ud         = ud_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;

`ifdef QUAD_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    // A clear that coincides with a new error restarts the count at one.
    always_comb begin
        err_count_d = err_count_q;
        if (bus.err_clr) begin
            err_count_d = err_d ? 8'd1 : 8'd0;
        end else if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign bus.err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_step_decoder
// Brief    : Directed vectors and corner sequences for quad_step_decoder
//            (FILTER_LEN=2, STEPS_PER_PULSE=4); honours QUAD_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_step_decoder;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    quad_step_decoder_if bus ();

    quad_step_decoder #(
        .FILTER_LEN      (2),
        .STEPS_PER_PULSE (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] ph;
        logic       en;
        int         steps;
        int         errs;
        logic       ud;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   step_seen = 0;
    int   err_seen  = 0;
    int   first;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.step) step_seen++;
        if (bus.err)  err_seen++;
    endtask

    task automatic hold(input logic [1:0] ph, input int n);
        bus.phase_b = ph[1];
        bus.phase_a = ph[0];
        repeat (n) tick();
    endtask

    task automatic add(input logic [1:0] ph, input logic en, input int s, input int e, input logic u);
        vec_t v;
        v.ph = ph; v.en = en; v.steps = s; v.errs = e; v.ud = u;
        vecs.push_back(v);
    endtask

    initial begin
        // {b,a} level, enable, steps in window, errs in window, ud afterwards
        add(2'b10, 1'b1, 0, 0, 1'b0); add(2'b11, 1'b1, 0, 0, 1'b0);
        add(2'b01, 1'b1, 0, 0, 1'b0); add(2'b00, 1'b1, 1, 0, 1'b1);
        add(2'b10, 1'b1, 0, 0, 1'b1); add(2'b11, 1'b1, 0, 0, 1'b1);
        add(2'b01, 1'b1, 0, 0, 1'b1); add(2'b00, 1'b1, 1, 0, 1'b1);
        add(2'b01, 1'b1, 0, 0, 1'b1); add(2'b11, 1'b1, 0, 0, 1'b1);
        add(2'b10, 1'b1, 0, 0, 1'b1); add(2'b00, 1'b1, 1, 0, 1'b0);
        add(2'b01, 1'b1, 0, 0, 1'b0); add(2'b11, 1'b1, 0, 0, 1'b0);
        add(2'b01, 1'b1, 0, 0, 1'b0); add(2'b00, 1'b1, 0, 0, 1'b0);
        add(2'b01, 1'b1, 0, 0, 1'b0); add(2'b11, 1'b1, 0, 0, 1'b0);
        add(2'b10, 1'b1, 0, 0, 1'b0); add(2'b00, 1'b1, 1, 0, 1'b0);
        // enable low across a full detent with acc parked at +2
        add(2'b01, 1'b1, 0, 0, 1'b0); add(2'b11, 1'b1, 0, 0, 1'b0);
        add(2'b10, 1'b0, 0, 0, 1'b0); add(2'b00, 1'b0, 0, 0, 1'b0);
        add(2'b01, 1'b0, 0, 0, 1'b0); add(2'b11, 1'b0, 0, 0, 1'b0);
        add(2'b10, 1'b1, 0, 0, 1'b0); add(2'b00, 1'b1, 1, 0, 1'b0);

        bus.phase_a = 1'b1;
        bus.phase_b = 1'b1;
        bus.enable  = 1'b1;
        bus.err_clr = 1'b0;
        reset       = 1'b0;
        repeat (3) tick();
        check("rst_step", int'(bus.step), 0);
        check("rst_ud", int'(bus.ud), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_sticky", int'(bus.err_sticky), 0);
`ifdef QUAD_ERR_CNT_EN
        check("rst_err_count", int'(bus.err_count), 0);
`endif

        reset = 1'b1;
        step_seen = 0; err_seen = 0;
        hold(2'b11, 12);
        check("idle_steps", step_seen, 0);
        check("idle_errs", err_seen, 0);
        check("idle_sticky", int'(bus.err_sticky), 0);
        check("idle_ud", int'(bus.ud), 0);

        reset = 1'b0;
        hold(2'b00, 3);
        reset = 1'b1;
        hold(2'b00, 12);

        // First detent: step must appear exactly 5 samples after driving 00
        step_seen = 0; err_seen = 0;
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10);
        bus.phase_a = 1'b0; bus.phase_b = 1'b0;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.step && first == 0) first = i;
        end
        check("fwd_step_latency", first, 5);
        check("fwd_steps", step_seen, 1);
        check("fwd_ud", int'(bus.ud), 0);
        check("fwd_errs", err_seen, 0);

        foreach (vecs[i]) begin
            step_seen = 0; err_seen = 0;
            bus.enable = vecs[i].en;
            hold(vecs[i].ph, 10);
            check($sformatf("vec%0d_steps", i), step_seen, vecs[i].steps);
            check($sformatf("vec%0d_errs", i), err_seen, vecs[i].errs);
            check($sformatf("vec%0d_ud", i), int'(bus.ud), int'(vecs[i].ud));
        end
        bus.enable = 1'b1;

        // Single-cycle glitches, one phase then both phases
        step_seen = 0; err_seen = 0;
        hold(2'b01, 1); hold(2'b00, 10);
        hold(2'b11, 1); hold(2'b00, 10);
        check("glitch_steps", step_seen, 0);
        check("glitch_errs", err_seen, 0);

        step_seen = 0; err_seen = 0;
        bus.phase_a = 1'b1; bus.phase_b = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.err && first == 0) first = i;
        end
        check("illegal_err_latency", first, 5);
        check("illegal_errs", err_seen, 1);
        check("illegal_steps", step_seen, 0);
        check("illegal_sticky", int'(bus.err_sticky), 1);
`ifdef QUAD_ERR_CNT_EN
        check("illegal_err_count", int'(bus.err_count), 1);
`endif

        // err_clr lands in the same cycle as the second illegal jump's error
        err_seen = 0;
        bus.phase_a = 1'b0; bus.phase_b = 1'b0;
        repeat (4) tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clr_err_pulse", int'(bus.err), 1);
        check("clr_err_sticky", int'(bus.err_sticky), 1);
`ifdef QUAD_ERR_CNT_EN
        check("clr_err_count", int'(bus.err_count), 1);
`endif
        hold(2'b00, 5);
        check("clr_err_total", err_seen, 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("lone_clr_sticky", int'(bus.err_sticky), 0);
`ifdef QUAD_ERR_CNT_EN
        check("lone_clr_count", int'(bus.err_count), 0);
`endif

        // Park mid-detent at acc=-3 with ud=1 and sticky set, then reset
        step_seen = 0; err_seen = 0;
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
        check("rev_steps", step_seen, 1);
        check("rev_ud", int'(bus.ud), 1);
        hold(2'b11, 10);
        check("pre_rst_sticky", int'(bus.err_sticky), 1);
        step_seen = 0;
        hold(2'b01, 10); hold(2'b00, 10); hold(2'b10, 10);
        check("partial_steps", step_seen, 0);
        reset = 1'b0;
        #1;
        check("midrst_step", int'(bus.step), 0);
        check("midrst_ud", int'(bus.ud), 0);
        check("midrst_err", int'(bus.err), 0);
        check("midrst_sticky", int'(bus.err_sticky), 0);
`ifdef QUAD_ERR_CNT_EN
        check("midrst_err_count", int'(bus.err_count), 0);
`endif
        repeat (3) tick();
        reset = 1'b1;
        hold(2'b10, 12);
        step_seen = 0; err_seen = 0;
        hold(2'b00, 10); hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10);
        check("post_rst_steps", step_seen, 1);
        check("post_rst_ud", int'(bus.ud), 0);
        check("post_rst_errs", err_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
